mp_arith_unit: RTL

Word-serial multi-precision add/subtract/compare/negate engine for signed two's-complement operands stored little-endian in single-port SRAM.
- Reads operand words from x1 and x2 regions and writes result words to the x3 region.
- Reports carry, zero, sign and signed-overflow flags.
- Sits beside the other arithmetic units behind the top-level SRAM arbiter; one operation runs at a time, sequenced by a start/done handshake.

---
 rtl/mp_arith_unit.sv | 248 ++++++++++++++++++++++++
 1 files changed

// File: rtl/mp_arith_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mp_arith_unit
//  Description : Word-serial multi-precision add / subtract / compare / negate
//                engine. Operands are signed two's complement, stored
//                little-endian in single-port SRAM. One word per three cycles
//                (read x1, read x2, execute + write x3). Reports carry, zero,
//                sign and signed-overflow flags.
//                Optional macro MP_ARITH_ABORT_EN adds an i_abort input that
//                terminates a running operation with all flags cleared.
//  Revision    : 1.0 - initial release
// ============================================================================
module mp_arith_unit #(
   parameter int ADRBW = 20,
   parameter int WRDBW = 16,
   parameter int LENBW = 12
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
`ifdef MP_ARITH_ABORT_EN
   input  logic             i_abort,
`endif
   input  logic             i_start,
   input  logic [1:0]       i_op,
   input  logic [LENBW-1:0] i_len,
   input  logic [ADRBW-1:0] i_x1addr,
   input  logic [ADRBW-1:0] i_x2addr,
   input  logic [ADRBW-1:0] i_x3addr,
   input  logic [WRDBW-1:0] i_rdata,
   output logic [ADRBW-1:0] o_addr,
   output logic             o_wen,
   output logic [WRDBW-1:0] o_wdata,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_carry,
   output logic             o_zero,
   output logic             o_neg,
   output logic             o_ovf
);

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_CMP = 2'b10;
   localparam logic [1:0] OP_NEG = 2'b11;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      LD1  = 3'd1,
      LD2  = 3'd2,
      EXE  = 3'd3,
      DONE = 3'd4
   } state_t;

   state_t             state;
   state_t             state_next;

   // Latched operation descriptor
   logic [1:0]         op;
   logic [LENBW-1:0]   len;
   logic [ADRBW-1:0]   x1base;
   logic [ADRBW-1:0]   x2base;
   logic [ADRBW-1:0]   x3base;

   // Word-serial datapath state
   logic [LENBW-1:0]   idx;
   logic [WRDBW-1:0]   a_word;
   logic               carry;
   logic               zero_acc;
   logic [ADRBW-1:0]   addr_hold;

   // Result flags, held from DONE until the next accepted start
   logic               flag_carry;
   logic               flag_zero;
   logic               flag_neg;
   logic               flag_ovf;

   // Combinational helpers
   logic               abort;
   logic [ADRBW-1:0]   idx_ext;
   logic               last_word;
   logic [WRDBW-1:0]   opa;
   logic [WRDBW-1:0]   opb;
   logic [WRDBW:0]     sum_full;
   logic [WRDBW-1:0]   sum;
   logic               cout;
   logic               cin_msb;
   logic [ADRBW-1:0]   addr_mux;
   logic               wen_c;
   logic [WRDBW-1:0]   wdata_c;
   logic               done_c;

`ifdef MP_ARITH_ABORT_EN
   assign abort = i_abort;
`else
   assign abort = 1'b0;
`endif

   assign idx_ext   = {{(ADRBW-LENBW){1'b0}}, idx};
   assign last_word = (idx == (len - {{(LENBW-1){1'b0}}, 1'b1}));

   // Operand selection and one-word add; SUB/CMP/NEG enter with carry = 1
   always_comb begin
      opa = a_word;
      opb = ~i_rdata;
      case (op)
         OP_ADD: begin
            opa = a_word;
            opb = i_rdata;
         end
         OP_NEG: begin
            opa = '0;
            opb = ~a_word;
         end
         default: begin
            opa = a_word;
            opb = ~i_rdata;
         end
      endcase
      sum_full = {1'b0, opa} + {1'b0, opb} + {{WRDBW{1'b0}}, carry};
      sum      = sum_full[WRDBW-1:0];
      cout     = sum_full[WRDBW];
      // Carry into the MSB recovered from the MSB's own sum bit
      cin_msb  = opa[WRDBW-1] ^ opb[WRDBW-1] ^ sum[WRDBW-1];
   end

   // State register
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic and SRAM port drive; address holds outside LD1/LD2/EXE
   always_comb begin
      state_next = state;
      addr_mux   = addr_hold;
      wen_c      = 1'b0;
      wdata_c    = '0;
      done_c     = 1'b0;
      case (state)
         IDLE: begin
            if (i_start) begin
               state_next = (i_len == '0) ? DONE : LD1;
            end
         end
         LD1: begin
            addr_mux   = x1base + idx_ext;
            state_next = abort ? DONE : LD2;
         end
         LD2: begin
            addr_mux   = x2base + idx_ext;
            state_next = abort ? DONE : EXE;
         end
         EXE: begin
            addr_mux   = x3base + idx_ext;
            wdata_c    = sum;
            wen_c      = (op != OP_CMP) && !abort;
            state_next = (abort || last_word) ? DONE : LD1;
         end
         DONE: begin
            done_c     = 1'b1;
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Operand latching, word loop bookkeeping and flag capture
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         op         <= OP_ADD;
         len        <= '0;
         x1base     <= '0;
         x2base     <= '0;
         x3base     <= '0;
         idx        <= '0;
         a_word     <= '0;
         carry      <= 1'b0;
         zero_acc   <= 1'b0;
         addr_hold  <= '0;
         flag_carry <= 1'b0;
         flag_zero  <= 1'b0;
         flag_neg   <= 1'b0;
         flag_ovf   <= 1'b0;
      end else begin
         addr_hold <= addr_mux;
         case (state)
            IDLE: begin
               if (i_start) begin
                  op       <= i_op;
                  len      <= i_len;
                  x1base   <= i_x1addr;
                  x2base   <= i_x2addr;
                  x3base   <= i_x3addr;
                  idx      <= '0;
                  carry    <= (i_op != OP_ADD);
                  zero_acc <= 1'b1;
                  flag_neg <= 1'b0;
                  flag_ovf <= 1'b0;
                  // A zero-length operation goes straight to DONE with its
                  // flags fixed here; otherwise they are produced by EXE
                  if (i_len == '0) begin
                     flag_carry <= (i_op != OP_ADD);
                     flag_zero  <= 1'b1;
                  end else begin
                     flag_carry <= 1'b0;
                     flag_zero  <= 1'b0;
                  end
               end
            end
            LD2: begin
               a_word <= i_rdata;
            end
            EXE: begin
               if (!abort) begin
                  carry    <= cout;
                  zero_acc <= zero_acc & (sum == '0);
                  idx      <= idx + {{(LENBW-1){1'b0}}, 1'b1};
                  if (last_word) begin
                     flag_carry <= cout;
                     flag_zero  <= zero_acc & (sum == '0);
                     flag_neg   <= sum[WRDBW-1];
                     flag_ovf   <= cin_msb ^ cout;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign o_addr  = addr_mux;
   assign o_wen   = wen_c;
   assign o_wdata = wdata_c;
   assign o_busy  = (state != IDLE);
   assign o_done  = done_c;
   assign o_carry = flag_carry;
   assign o_zero  = flag_zero;
   assign o_neg   = flag_neg;
   assign o_ovf   = flag_ovf;

endmodule
`default_nettype wire
